pair_buffer_arbiter: RTL and testbench

Downstream stage of the position-data preprocessor. It accepts up to NUM_FILTER candidate pairs per cycle, each as a per-filter `pair_valid` bit and a 3×DATA_WIDTH position slice, and buffers each filter lane in its own FIFO. A round-robin arbiter drains one pair per cycle into a registered valid/ready output toward the force pipeline. It also generates `pause_reading` back-pressure for the reading logic upstream.

---
 rtl/pair_buffer_arbiter.sv | 127 ++++++++++++
 tb/tb_pair_buffer_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pair_buffer_arbiter.sv
// Per-lane pair FIFOs drained by a round-robin arbiter into a registered
// valid/ready output, with occupancy-based pause back-pressure upstream.
module pair_buffer_arbiter #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned NUM_FILTER        = 7,
  parameter int unsigned PARTICLE_ID_WIDTH = 7,
  parameter int unsigned FIFO_DEPTH        = 8,
  parameter int unsigned PAUSE_MARGIN      = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_FILTER-1:0]                pair_valid,
  input  logic [NUM_FILTER*3*DATA_WIDTH-1:0]   assembled_position,
  input  logic [PARTICLE_ID_WIDTH-1:0]         pair_ref_id,
  input  logic                                 out_ready,
  output logic                                 out_valid,
  output logic [3*DATA_WIDTH-1:0]              out_position,
  output logic [PARTICLE_ID_WIDTH-1:0]         out_ref_id,
  output logic [$clog2(NUM_FILTER)-1:0]        out_filter_id,
  output logic                                 pause_reading,
  output logic                                 buffer_empty,
  output logic                                 overflow
);

  localparam int unsigned POS_W    = 3 * DATA_WIDTH;
  localparam int unsigned ENT_W    = POS_W + PARTICLE_ID_WIDTH;
  localparam int unsigned FID_W    = $clog2(NUM_FILTER);
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned PAUSE_TH = FIFO_DEPTH - PAUSE_MARGIN;

  logic [NUM_FILTER-1:0]            nonempty;
  logic [NUM_FILTER-1:0]            near_full;
  logic [NUM_FILTER-1:0]            drop;
  logic [NUM_FILTER-1:0][ENT_W-1:0] head;
  logic [ENT_W-1:0]                 head_sel;
  logic [FID_W-1:0]                 grant;
  logic [FID_W-1:0]                 last_grant;
  logic                             grant_found;
  logic                             load;

  for (genvar f = 0; f < NUM_FILTER; f++) begin : g_lane
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             full;
    logic             push;
    logic             pop;

    // Lane push/pop/drop decisions; a full lane still accepts when popped this cycle.
    always_comb begin
      full         = (count == CNT_W'(FIFO_DEPTH));
      pop          = load && (grant == FID_W'(f));
      push         = pair_valid[f] && (!full || pop);
      drop[f]      = pair_valid[f] && full && !pop;
      count_nxt    = count + CNT_W'(push) - CNT_W'(pop);
      nonempty[f]  = (count != '0);
      near_full[f] = (count_nxt >= CNT_W'(PAUSE_TH));
      head[f]      = mem[rd_ptr];
    end

    // Lane occupancy and pointers; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk) begin
      if (rst) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        count <= count_nxt;
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end

    // Lane storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {assembled_position[f*POS_W +: POS_W], pair_ref_id};
    end
  end

  // Round-robin search starting just after the last granted lane.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant       = '0;
    grant_found = 1'b0;
    for (int unsigned i = 1; i <= NUM_FILTER; i++) begin
      idx = (32'(last_grant) + i) % NUM_FILTER;
      if (!grant_found && nonempty[FID_W'(idx)]) begin
        grant       = FID_W'(idx);
        grant_found = 1'b1;
      end
    end
    load     = (!out_valid || out_ready) && grant_found;
    head_sel = head[grant];
  end

  // Output register, arbiter history, pause and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_position  <= '0;
      out_ref_id    <= '0;
      out_filter_id <= '0;
      last_grant    <= FID_W'(NUM_FILTER - 1);
      pause_reading <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (load) begin
        out_valid     <= 1'b1;
        out_position  <= head_sel[ENT_W-1:PARTICLE_ID_WIDTH];
        out_ref_id    <= head_sel[PARTICLE_ID_WIDTH-1:0];
        out_filter_id <= grant;
        last_grant    <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      pause_reading <= |near_full;
      if (|drop) overflow <= 1'b1;
    end
  end

  assign buffer_empty = !out_valid && !(|nonempty);

endmodule

// File: tb/tb_pair_buffer_arbiter.sv
// Randomized and directed bench for pair_buffer_arbiter against a queue-based model.
module tb_pair_buffer_arbiter;

  localparam int unsigned DW     = 32;
  localparam int unsigned NF     = 7;
  localparam int unsigned PID_W  = 7;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned MARGIN = 3;
  localparam int unsigned POS_W  = 3 * DW;
  localparam int unsigned ENT_W  = POS_W + PID_W;
  localparam int unsigned FID_W  = $clog2(NF);

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NF-1:0]         pair_valid;
  logic [NF*POS_W-1:0]   assembled_position;
  logic [PID_W-1:0]      pair_ref_id;
  logic                  out_ready;
  logic                  out_valid;
  logic [POS_W-1:0]      out_position;
  logic [PID_W-1:0]      out_ref_id;
  logic [FID_W-1:0]      out_filter_id;
  logic                  pause_reading;
  logic                  buffer_empty;
  logic                  overflow;

  pair_buffer_arbiter #(
    .DATA_WIDTH(DW), .NUM_FILTER(NF), .PARTICLE_ID_WIDTH(PID_W),
    .FIFO_DEPTH(DEPTH), .PAUSE_MARGIN(MARGIN)
  ) dut (
    .clk(clk), .rst(rst), .pair_valid(pair_valid),
    .assembled_position(assembled_position), .pair_ref_id(pair_ref_id),
    .out_ready(out_ready), .out_valid(out_valid), .out_position(out_position),
    .out_ref_id(out_ref_id), .out_filter_id(out_filter_id),
    .pause_reading(pause_reading), .buffer_empty(buffer_empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: one queue per lane plus the output register contents.
  logic [ENT_W-1:0] mq [NF][$];
  bit               m_ov;
  logic [POS_W-1:0] m_pos;
  logic [PID_W-1:0] m_rid;
  int               m_fid;
  int               m_lg;
  bit               m_pause;
  bit               m_ovf;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_step(input logic r, input logic [NF-1:0] pv,
                            input logic [NF*POS_W-1:0] pos, input logic [PID_W-1:0] rid,
                            input logic rdy);
    bit any;
    bit found;
    logic [ENT_W-1:0] e;
    if (r) begin
      for (int f = 0; f < NF; f++) mq[f].delete();
      m_ov = 0; m_pos = '0; m_rid = '0; m_fid = 0; m_lg = NF - 1;
      m_pause = 0; m_ovf = 0;
      return;
    end
    any = 0;
    for (int f = 0; f < NF; f++) if (mq[f].size() > 0) any = 1;
    if ((!m_ov || rdy) && any) begin
      found = 0;
      for (int i = 1; i <= NF; i++) begin
        int g;
        g = (m_lg + i) % NF;
        if (!found && mq[g].size() > 0) begin
          e = mq[g].pop_front();
          m_pos = e[ENT_W-1:PID_W];
          m_rid = e[PID_W-1:0];
          m_fid = g;
          m_lg  = g;
          found = 1;
        end
      end
      m_ov = 1;
    end else if (rdy) begin
      m_ov = 0;
    end
    for (int f = 0; f < NF; f++) begin
      if (pv[f]) begin
        if (mq[f].size() < DEPTH) mq[f].push_back({pos[f*POS_W +: POS_W], rid});
        else m_ovf = 1;
      end
    end
    m_pause = 0;
    for (int f = 0; f < NF; f++) if (mq[f].size() >= DEPTH - MARGIN) m_pause = 1;
  endtask

  task automatic compare_all();
    bit empty;
    empty = !m_ov;
    for (int f = 0; f < NF; f++) if (mq[f].size() > 0) empty = 0;
    check("out_valid",     96'(out_valid),     96'(m_ov));
    check("out_position",  96'(out_position),  96'(m_pos));
    check("out_ref_id",    96'(out_ref_id),    96'(m_rid));
    check("out_filter_id", 96'(out_filter_id), 96'(m_fid));
    check("pause_reading", 96'(pause_reading), 96'(m_pause));
    check("buffer_empty",  96'(buffer_empty),  96'(empty));
    check("overflow",      96'(overflow),      96'(m_ovf));
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic cycle(input logic r, input logic [NF-1:0] pv,
                       input logic [NF*POS_W-1:0] pos, input logic [PID_W-1:0] rid,
                       input logic rdy);
    rst = r; pair_valid = pv; assembled_position = pos; pair_ref_id = rid; out_ready = rdy;
    model_step(r, pv, pos, rid, rdy);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  function automatic logic [NF*POS_W-1:0] lane_pos(input int f, input logic [POS_W-1:0] p);
    logic [NF*POS_W-1:0] v;
    v = '0;
    v[f*POS_W +: POS_W] = p;
    return v;
  endfunction

  function automatic logic [NF*POS_W-1:0] rand_pos();
    logic [NF*POS_W-1:0] v;
    for (int w = 0; w < NF * 3; w++) v[w*DW +: DW] = $urandom();
    return v;
  endfunction

  localparam logic [NF*POS_W-1:0] NOPOS = '0;

  initial begin
    logic [POS_W-1:0] p3;
    int mode;

    // Reset state
    cycle(1, '0, NOPOS, '0, 1);
    cycle(1, '0, NOPOS, '0, 1);
    check("rst_buffer_empty", 96'(buffer_empty), 96'(1));
    check("rst_out_valid", 96'(out_valid), 96'(0));

    // Single pair on lane 3, one-cycle latency
    p3 = {32'h11, 32'h22, 32'h33};
    cycle(0, NF'(1 << 3), lane_pos(3, p3), 7'd5, 1);
    check("s1_not_bypassed", 96'(out_valid), 96'(0));
    cycle(0, '0, NOPOS, '0, 1);
    check("s1_valid", 96'(out_valid), 96'(1));
    check("s1_fid", 96'(out_filter_id), 96'(3));
    check("s1_pos", 96'(out_position), {64'h0000_0011_0000_0022, 32'h33});
    check("s1_rid", 96'(out_ref_id), 96'(5));
    cycle(0, '0, NOPOS, '0, 1);
    check("s1_empty_after", 96'(buffer_empty), 96'(1));

    // All lanes at once after reset: grants 0..6 with no bubbles
    cycle(1, '0, NOPOS, '0, 1);
    cycle(0, '1, rand_pos(), 7'd9, 1);
    for (int i = 0; i < NF; i++) begin
      cycle(0, '0, NOPOS, '0, 1);
      check("s2_valid", 96'(out_valid), 96'(1));
      check("s2_fid", 96'(out_filter_id), 96'(i));
    end
    cycle(0, '0, NOPOS, '0, 1);

    // Lane 0 fed continuously with the output stalled: pause, then overflow
    cycle(1, '0, NOPOS, '0, 0);
    for (int i = 0; i < 10; i++) cycle(0, NF'(1), rand_pos(), PID_W'(i), 0);
    check("s3_pause", 96'(pause_reading), 96'(1));
    check("s3_overflow", 96'(overflow), 96'(1));

    // Lane 2 full, pop and push in the same cycle: no drop, new pair last
    cycle(1, '0, NOPOS, '0, 0);
    for (int i = 1; i <= 9; i++) cycle(0, NF'(1 << 2), rand_pos(), PID_W'(i), 0);
    cycle(0, NF'(1 << 2), rand_pos(), 7'h55, 1);
    check("s4_no_overflow", 96'(overflow), 96'(0));
    for (int i = 0; i < 10; i++) cycle(0, '0, NOPOS, '0, 1);
    check("s4_last_rid", 96'(out_ref_id), 96'(7'h55));
    check("s4_drained", 96'(buffer_empty), 96'(1));

    // Lanes 1 and 4 with two pairs each, out_ready 1,0,0,1
    cycle(1, '0, NOPOS, '0, 0);
    cycle(0, NF'((1 << 1) | (1 << 4)), rand_pos(), 7'd1, 0);
    cycle(0, NF'((1 << 1) | (1 << 4)), rand_pos(), 7'd2, 0);
    check("s5_first_fid", 96'(out_filter_id), 96'(1));
    cycle(0, '0, NOPOS, '0, 1);
    check("s5_second_fid", 96'(out_filter_id), 96'(4));
    cycle(0, '0, NOPOS, '0, 0);
    cycle(0, '0, NOPOS, '0, 0);
    check("s5_stall_fid", 96'(out_filter_id), 96'(4));
    cycle(0, '0, NOPOS, '0, 1);
    check("s5_third_fid", 96'(out_filter_id), 96'(1));
    for (int i = 0; i < 3; i++) cycle(0, '0, NOPOS, '0, 1);

    // Reset mid-operation flushes everything
    cycle(0, NF'((1 << 0) | (1 << 3) | (1 << 5)), rand_pos(), 7'd3, 0);
    cycle(0, NF'((1 << 0) | (1 << 3) | (1 << 5)), rand_pos(), 7'd4, 0);
    cycle(1, '0, NOPOS, '0, 0);
    check("s6_valid", 96'(out_valid), 96'(0));
    check("s6_empty", 96'(buffer_empty), 96'(1));
    check("s6_pause", 96'(pause_reading), 96'(0));
    for (int i = 0; i < 5; i++) cycle(0, '0, NOPOS, '0, 1);
    check("s6_no_stale", 96'(out_valid), 96'(0));

    // Randomized traffic with varying density and back-pressure
    for (int c = 0; c < 3000; c++) begin
      logic [NF-1:0] pv;
      logic          rdy;
      logic          r;
      mode = (c / 200) % 3;
      case (mode)
        0:       pv = NF'($urandom() & $urandom() & $urandom());
        1:       pv = NF'($urandom() & $urandom());
        default: pv = NF'($urandom());
      endcase
      rdy = (mode == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 299) == 0);
      cycle(r, pv, rand_pos(), PID_W'($urandom()), rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
